mem_wb_pipe_stage: RTL and testbench

- Parametrised MEM->WB pipeline stage. It replaces the fixed-width, always-advancing MEM/WB register.
- Adds valid/ready flow control with a 2-entry skid buffer, so the upstream ready is registered.
- Adds synchronous flush, x0 write suppression and a saturating stall counter.
- Sits between the data-memory stage and register-file writeback.
- Latency is 1 cycle. Throughput is 1 transfer per cycle.

---
 rtl/mem_wb_pkg.sv | 36 +++
 rtl/mem_wb_pipe_stage_slot.sv | 42 ++++
 rtl/mem_wb_pipe_stage.sv | 175 +++++++++++++++++
 tb/tb_mem_wb_pipe_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared definitions for the MEM->WB pipeline stage.
//   - FSM state encoding (EMPTY / BUSY / FULL)
//   - payload width helper and payload field offsets
// Payload layout, MSB to LSB:
//   {reg_write, mem_to_reg, read_data[DATA_W], alu_result[DATA_W], rd[RD_W]}
package mem_wb_pkg;

  localparam logic [1:0] EMPTY = 2'd0;  // no entry held
  localparam logic [1:0] BUSY  = 2'd1;  // main slot holds an entry
  localparam logic [1:0] FULL  = 2'd2;  // main and skid slots both hold entries

  function automatic int PAYLOAD_W(input int data_w, input int rd_w);
    return 2 * data_w + rd_w + 2;
  endfunction

  function automatic int off_rd();
    return 0;
  endfunction

  function automatic int off_alu(input int rd_w);
    return rd_w;
  endfunction

  function automatic int off_read_data(input int data_w, input int rd_w);
    return rd_w + data_w;
  endfunction

  function automatic int off_mem_to_reg(input int data_w, input int rd_w);
    return rd_w + 2 * data_w;
  endfunction

  function automatic int off_reg_write(input int data_w, input int rd_w);
    return rd_w + 2 * data_w + 1;
  endfunction

endpackage

// File: rtl/mem_wb_pipe_stage_slot.sv
// pipe_slot: one storage slot of the MEM->WB stage, a valid bit plus a
// payload register.
// Ports:
//   i_clk    rising-edge clock
//   i_rst    asynchronous active-high reset (clears valid and payload)
//   i_load   capture i_data and set valid
//   i_clear  drop the entry (valid <= 0); payload keeps its stale value
//   i_data   payload to capture
//   o_valid  slot holds an entry
//   o_data   held payload
// i_clear wins over i_load so a flush always empties the slot.
module pipe_slot #(
  parameter int PW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic          i_clear,
  input  logic [PW-1:0] i_data,
  output logic          o_valid,
  output logic [PW-1:0] o_data
);

  logic          r_valid;
  logic [PW-1:0] r_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// mem_wb_pipe_stage: MEM->WB pipeline register with valid/ready flow
// control, a 2-entry skid buffer, synchronous flush, x0 write suppression
// and a saturating stall counter. Latency 1 cycle, throughput 1/cycle.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   flush                      synchronous flush of held and incoming entries
//   valid_m / ready_m          upstream handshake (ready_m is registered)
//   reg_write_m .. rd_m        upstream payload
//   valid_w / ready_w          downstream handshake
//   reg_write_w .. rd_w        payload from the main slot (reg_write qualified)
//   stall_cnt                  saturating count of back-pressured cycles
//   dbg_state                  current FSM state (EMPTY/BUSY/FULL)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. valid_w/payload stay stable while valid_w & ~ready_w. ready_m
// is ~skid_valid, taken straight from the skid slot register, so there is
// no combinational path from ready_w to ready_m.
module mem_wb_pipe_stage
  import mem_wb_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int RD_W        = 5,
  parameter int CNT_W       = 16,
  parameter int SUPPRESS_X0 = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              valid_m,
  output logic              ready_m,
  input  logic              reg_write_m,
  input  logic              mem_to_reg_m,
  input  logic [DATA_W-1:0] read_data_m,
  input  logic [DATA_W-1:0] alu_result_m,
  input  logic [RD_W-1:0]   rd_m,
  output logic              valid_w,
  input  logic              ready_w,
  output logic              reg_write_w,
  output logic              mem_to_reg_w,
  output logic [DATA_W-1:0] read_data_w,
  output logic [DATA_W-1:0] alu_result_w,
  output logic [RD_W-1:0]   rd_w,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        dbg_state
);

  localparam int PW       = PAYLOAD_W(DATA_W, RD_W);
  localparam int O_RD     = off_rd();
  localparam int O_ALU    = off_alu(RD_W);
  localparam int O_RDATA  = off_read_data(DATA_W, RD_W);
  localparam int O_M2R    = off_mem_to_reg(DATA_W, RD_W);
  localparam int O_RW     = off_reg_write(DATA_W, RD_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [PW-1:0] w_in_payload;
  logic [PW-1:0] w_main_din;
  logic [PW-1:0] w_main_data;
  logic [PW-1:0] w_skid_data;
  logic          w_main_valid;
  logic          w_skid_valid;
  logic          w_main_load;
  logic          w_main_clear;
  logic          w_skid_load;
  logic          w_skid_clear;
  logic          w_accept;
  logic          w_retire;
  logic          w_x0_ok;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_in_payload = {reg_write_m, mem_to_reg_m, read_data_m, alu_result_m, rd_m};
  assign w_accept     = valid_m & ready_m;
  assign w_retire     = valid_w & ready_w;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_state_next;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY:   if (w_accept) w_state_next = BUSY;
        BUSY: begin
          if (w_accept && !w_retire)      w_state_next = FULL;
          else if (!w_accept && w_retire) w_state_next = EMPTY;
        end
        FULL:    if (w_retire) w_state_next = BUSY;
        default: w_state_next = EMPTY;
      endcase
    end
  end

  // Slot control outputs
  always_comb begin
    w_main_load  = 1'b0;
    w_main_clear = 1'b0;
    w_main_din   = w_in_payload;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
    if (flush) begin
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      case (r_state)
        EMPTY: w_main_load = w_accept;
        BUSY: begin
          if (w_accept && w_retire)       w_main_load  = 1'b1;
          else if (w_accept)              w_skid_load  = 1'b1;
          else if (w_retire)              w_main_clear = 1'b1;
        end
        FULL: begin
          // Skid entry moves up only when main retires, preserving order
          if (w_retire) begin
            w_main_din   = w_skid_data;
            w_main_load  = 1'b1;
            w_skid_clear = 1'b1;
          end
        end
        default: begin
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
        end
      endcase
    end
  end

  pipe_slot #(.PW(PW)) u_main (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_din),
    .o_valid (w_main_valid),
    .o_data  (w_main_data)
  );

  pipe_slot #(.PW(PW)) u_skid (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (w_in_payload),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );

  // Stall counter saturates rather than wrapping; only reset clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (valid_w && !ready_w && !flush && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign w_x0_ok = (SUPPRESS_X0 == 0) || (rd_w != '0);

  assign valid_w      = w_main_valid;
  assign ready_m      = ~w_skid_valid;
  assign reg_write_w  = w_main_data[O_RW] & w_main_valid & w_x0_ok;
  assign mem_to_reg_w = w_main_data[O_M2R];
  assign read_data_w  = w_main_data[O_RDATA +: DATA_W];
  assign alu_result_w = w_main_data[O_ALU +: DATA_W];
  assign rd_w         = w_main_data[O_RD +: RD_W];
  assign stall_cnt    = r_stall_cnt;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Bench for mem_wb_pipe_stage. Three instances share one stimulus stream:
//   dut_a: default parameters
//   dut_b: SUPPRESS_X0 = 0
//   dut_c: CNT_W = 3
module tb_mem_wb_pipe_stage;
  import mem_wb_pkg::*;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        valid_m;
  logic        reg_write_m;
  logic        mem_to_reg_m;
  logic [63:0] read_data_m;
  logic [63:0] alu_result_m;
  logic [4:0]  rd_m;
  logic        ready_w;

  logic        a_ready_m, a_valid_w, a_rw, a_m2r;
  logic [63:0] a_rdata, a_alu;
  logic [4:0]  a_rd;
  logic [15:0] a_cnt;
  logic [1:0]  a_st;
  logic        b_ready_m, b_valid_w, b_rw, b_m2r;
  logic [63:0] b_rdata, b_alu;
  logic [4:0]  b_rd;
  logic [15:0] b_cnt;
  logic [1:0]  b_st;
  logic        c_ready_m, c_valid_w, c_rw, c_m2r;
  logic [63:0] c_rdata, c_alu;
  logic [4:0]  c_rd;
  logic [2:0]  c_cnt;
  logic [1:0]  c_st;

  int n_applied = 0;
  int n_miss    = 0;

  // ---------------- clock / DUTs ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  mem_wb_pipe_stage dut_a (
    .clk(clk), .reset(reset), .flush(flush), .valid_m(valid_m), .ready_m(a_ready_m),
    .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m), .read_data_m(read_data_m),
    .alu_result_m(alu_result_m), .rd_m(rd_m), .valid_w(a_valid_w), .ready_w(ready_w),
    .reg_write_w(a_rw), .mem_to_reg_w(a_m2r), .read_data_w(a_rdata),
    .alu_result_w(a_alu), .rd_w(a_rd), .stall_cnt(a_cnt), .dbg_state(a_st)
  );

  mem_wb_pipe_stage #(.SUPPRESS_X0(0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .valid_m(valid_m), .ready_m(b_ready_m),
    .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m), .read_data_m(read_data_m),
    .alu_result_m(alu_result_m), .rd_m(rd_m), .valid_w(b_valid_w), .ready_w(ready_w),
    .reg_write_w(b_rw), .mem_to_reg_w(b_m2r), .read_data_w(b_rdata),
    .alu_result_w(b_alu), .rd_w(b_rd), .stall_cnt(b_cnt), .dbg_state(b_st)
  );

  mem_wb_pipe_stage #(.CNT_W(3)) dut_c (
    .clk(clk), .reset(reset), .flush(flush), .valid_m(valid_m), .ready_m(c_ready_m),
    .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m), .read_data_m(read_data_m),
    .alu_result_m(alu_result_m), .rd_m(rd_m), .valid_w(c_valid_w), .ready_w(ready_w),
    .reg_write_w(c_rw), .mem_to_reg_w(c_m2r), .read_data_w(c_rdata),
    .alu_result_w(c_alu), .rd_w(c_rd), .stall_cnt(c_cnt), .dbg_state(c_st)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic        v;      // valid_m
    logic        rw;     // reg_write_m
    logic [4:0]  rd;     // rd_m (data fields derived from it)
    logic        rdy;    // ready_w
    logic        fl;     // flush
    logic        ev;     // expected valid_w
    logic        erm;    // expected ready_m
    logic [4:0]  erd;    // expected rd_w (checked when ev)
    logic        erw;    // expected reg_write_w with x0 suppression
    logic        eraw;   // expected reg_write_w without suppression
    logic [1:0]  est;    // expected state
    int unsigned estall; // expected 16-bit stall count
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] rdata_of(input logic [4:0] rd);
    return 64'hD00D_0000_0000_0000 | {59'd0, rd};
  endfunction

  function automatic logic [63:0] alu_of(input logic [4:0] rd);
    return 64'hA1A1_0000_0000_0000 | {51'd0, rd, 8'h5C};
  endfunction

  task automatic add(input logic v, input logic rw, input logic [4:0] rd, input logic rdy,
                     input logic fl, input logic ev, input logic erm, input logic [4:0] erd,
                     input logic erw, input logic eraw, input logic [1:0] est,
                     input int unsigned estall);
    vec_t t;
    t.v = v; t.rw = rw; t.rd = rd; t.rdy = rdy; t.fl = fl;
    t.ev = ev; t.erm = erm; t.erd = erd; t.erw = erw; t.eraw = eraw;
    t.est = est; t.estall = estall;
    vecs.push_back(t);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_dut(input string tag, input vec_t t, input logic exp_rw,
                           input int unsigned exp_cnt, input logic vw, input logic rm,
                           input logic rwo, input logic m2r, input logic [63:0] rdd,
                           input logic [63:0] alu, input logic [4:0] rd, input logic [1:0] st,
                           input logic [15:0] cnt);
    check({tag, " valid_w"},     {63'd0, vw},  {63'd0, t.ev});
    check({tag, " ready_m"},     {63'd0, rm},  {63'd0, t.erm});
    check({tag, " state"},       {62'd0, st},  {62'd0, t.est});
    check({tag, " reg_write_w"}, {63'd0, rwo}, {63'd0, exp_rw});
    check({tag, " stall_cnt"},   {48'd0, cnt}, {32'd0, exp_cnt});
    if (t.ev) begin
      check({tag, " rd_w"},         {59'd0, rd},  {59'd0, t.erd});
      check({tag, " mem_to_reg_w"}, {63'd0, m2r}, {63'd0, t.erd[0]});
      check({tag, " read_data_w"},  rdd,          rdata_of(t.erd));
      check({tag, " alu_result_w"}, alu,          alu_of(t.erd));
    end
  endtask

  task automatic check_all(input string tag, input vec_t t);
    int unsigned sat;
    sat = (t.estall > 7) ? 7 : t.estall;
    check_dut({tag, " a"}, t, t.erw,  t.estall, a_valid_w, a_ready_m, a_rw, a_m2r,
              a_rdata, a_alu, a_rd, a_st, a_cnt);
    check_dut({tag, " b"}, t, t.eraw, t.estall, b_valid_w, b_ready_m, b_rw, b_m2r,
              b_rdata, b_alu, b_rd, b_st, b_cnt);
    check_dut({tag, " c"}, t, t.erw,  sat,      c_valid_w, c_ready_m, c_rw, c_m2r,
              c_rdata, c_alu, c_rd, c_st, {13'd0, c_cnt});
  endtask

  // ---------------- driver ----------------
  task automatic drive_idle();
    valid_m = 1'b0; reg_write_m = 1'b0; mem_to_reg_m = 1'b0; rd_m = 5'd0;
    read_data_m = 64'd0; alu_result_m = 64'd0; ready_w = 1'b0; flush = 1'b0;
  endtask

  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    valid_m      = t.v;
    reg_write_m  = t.rw;
    rd_m         = t.rd;
    mem_to_reg_m = t.rd[0];
    read_data_m  = rdata_of(t.rd);
    alu_result_m = alu_of(t.rd);
    ready_w      = t.rdy;
    flush        = t.fl;
    @(posedge clk);
    #1;
    check_all(tag, t);
  endtask

  task automatic check_reset_state(input string tag);
    vec_t t;
    t = '{v:0, rw:0, rd:0, rdy:0, fl:0, ev:0, erm:1, erd:0, erw:0, eraw:0, est:EMPTY, estall:0};
    check_all(tag, t);
    check({tag, " rd_w zero"},      {59'd0, a_rd},  64'd0);
    check({tag, " m2r zero"},       {63'd0, a_m2r}, 64'd0);
    check({tag, " read_data zero"}, a_rdata,        64'd0);
    check({tag, " alu zero"},       a_alu,          64'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t t;
    drive_idle();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1 check_reset_state("por");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    //   v  rw rd  rdy fl | ev rm erd erw eraw state  stall
    // Streaming, ready_w = 1
    add(1, 1, 1,  1, 0,   1, 1, 1,  1, 1,   BUSY,  0);
    add(1, 1, 2,  1, 0,   1, 1, 2,  1, 1,   BUSY,  0);
    add(1, 1, 3,  1, 0,   1, 1, 3,  1, 1,   BUSY,  0);
    add(1, 1, 4,  1, 0,   1, 1, 4,  1, 1,   BUSY,  0);
    add(0, 0, 0,  1, 0,   0, 1, 0,  0, 0,   EMPTY, 0);
    // Back-pressure: A (rd 5) then B (rd 6) with ready_w = 0
    add(1, 1, 5,  0, 0,   1, 1, 5,  1, 1,   BUSY,  0);
    add(1, 1, 6,  0, 0,   1, 0, 5,  1, 1,   FULL,  1);
    add(1, 1, 7,  0, 0,   1, 0, 5,  1, 1,   FULL,  2);
    add(0, 0, 0,  0, 0,   1, 0, 5,  1, 1,   FULL,  3);
    add(0, 0, 0,  1, 0,   1, 1, 6,  1, 1,   BUSY,  3);
    add(0, 0, 0,  1, 0,   0, 1, 0,  0, 0,   EMPTY, 3);
    // Flush while FULL with valid_m = 1; rd 10 must never appear
    add(1, 1, 8,  0, 0,   1, 1, 8,  1, 1,   BUSY,  3);
    add(1, 1, 9,  0, 0,   1, 0, 8,  1, 1,   FULL,  4);
    add(1, 1, 10, 0, 1,   0, 1, 0,  0, 0,   EMPTY, 4);
    add(0, 0, 0,  1, 0,   0, 1, 0,  0, 0,   EMPTY, 4);
    // x0 suppression
    add(1, 1, 0,  1, 0,   1, 1, 0,  0, 1,   BUSY,  4);
    add(1, 0, 3,  1, 0,   1, 1, 3,  0, 0,   BUSY,  4);
    add(0, 0, 0,  1, 0,   0, 1, 0,  0, 0,   EMPTY, 4);
    // Saturation: one entry held 10 back-pressured cycles
    add(1, 1, 11, 0, 0,   1, 1, 11, 1, 1,   BUSY,  4);
    for (int i = 0; i < 10; i++)
      add(0, 0, 0, 0, 0,  1, 1, 11, 1, 1,   BUSY,  5 + i);
    add(1, 1, 12, 0, 0,   1, 0, 11, 1, 1,   FULL,  15);

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset between edges while FULL
    @(negedge clk);
    drive_idle();
    #2 reset = 1'b1;
    #1 check_reset_state("async_rst");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // First accept after reset release
    t = '{v:1, rw:1, rd:13, rdy:1, fl:0, ev:1, erm:1, erd:13, erw:1, eraw:1, est:BUSY, estall:0};
    apply(t, "post_rst_accept");
    t = '{v:0, rw:0, rd:0, rdy:1, fl:0, ev:0, erm:1, erd:0, erw:0, eraw:0, est:EMPTY, estall:0};
    apply(t, "post_rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
